fir_mac_scheduler: RTL

- Time-multiplexed FIR engine controller: accepts one signed sample per handshake, stores it in a circular delay line and sequences a single shared multiply-accumulate over TAPS coefficients.
- Presents the 32-bit result on a valid/ready output.
- Holds a runtime-writable coefficient register file.
- Replaces the fully parallel FIR when multiplier count must be minimised.

---
 rtl/fir_mac_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR controller. One signed sample is accepted per handshake and
// stored in a circular delay line. A single shared multiply-accumulate then walks the
// TAPS coefficients, one tap per cycle, and the sum is offered on a valid/ready output.
// Coefficients live in a runtime-writable register file that is written only while idle.
module fir_mac_scheduler #(
  parameter int unsigned TAPS = 4,
  parameter int unsigned AW   = 2,
  parameter int unsigned DW   = 16,
  parameter int unsigned OW   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x_in,
  output logic signed [OW-1:0] y_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic signed [DW-1:0] cfg_data,
  input  logic                 flush,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                state_q, state_d;
  logic signed [DW-1:0]  hist_q [TAPS];
  logic signed [DW-1:0]  hist_d [TAPS];
  logic signed [DW-1:0]  coef_q [TAPS];
  logic signed [DW-1:0]  coef_d [TAPS];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         base_q, base_d;
  logic [AW-1:0]         k_q, k_d;
  logic signed [OW-1:0]  acc_q, acc_d;
  logic signed [OW-1:0]  y_q, y_d;
  logic                  out_valid_q, out_valid_d;

  logic [AW-1:0]         tap_idx;
  logic signed [2*DW-1:0] prod;
  logic signed [OW-1:0]  mac_sum;
  logic                  last_tap;
  logic                  wr_ptr_last;
  logic                  cfg_addr_ok;

  // Sample slot for the current tap: (base - k) mod TAPS, walking back in time.
  always_comb begin
    if (base_q >= k_q) begin
      tap_idx = base_q - k_q;
    end else begin
      tap_idx = AW'(32'(base_q) + TAPS - 32'(k_q));
    end
  end

  // Shared multiplier; the product is sign-extended before the wrapping accumulate.
  always_comb begin
    prod        = coef_q[k_q] * hist_q[tap_idx];
    mac_sum     = acc_q + OW'(prod);
    last_tap    = (k_q == AW'(TAPS - 1));
    wr_ptr_last = (wr_ptr_q == AW'(TAPS - 1));
    cfg_addr_ok = (32'(cfg_addr) < TAPS);
  end

  // A config write or a flush in the same cycle holds the sample off.
  always_comb begin
    in_ready  = (state_q == StIdle) & ~cfg_we & ~flush;
    busy      = (state_q != StIdle);
    y_out     = y_q;
    out_valid = out_valid_q;
  end

  // Next-state logic: flush overrides everything, cfg write overrides accept.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    coef_d      = coef_q;
    wr_ptr_d    = wr_ptr_q;
    base_d      = base_q;
    k_d         = k_q;
    acc_d       = acc_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        hist_d[i] = '0;
      end
      wr_ptr_d    = '0;
      acc_d       = '0;
      k_d         = '0;
      out_valid_d = 1'b0;
      state_d     = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_we) begin
            if (cfg_addr_ok) begin
              coef_d[cfg_addr] = cfg_data;
            end
          end else if (in_valid) begin
            hist_d[wr_ptr_q] = x_in;
            acc_d            = '0;
            k_d              = '0;
            base_d           = wr_ptr_q;
            wr_ptr_d         = wr_ptr_last ? '0 : wr_ptr_q + AW'(1);
            state_d          = StMac;
          end
        end
        StMac: begin
          acc_d = mac_sum;
          k_d   = k_q + AW'(1);
          if (last_tap) begin
            y_d         = mac_sum;
            out_valid_d = 1'b1;
            k_d         = '0;
            state_d     = StOut;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State registers; asynchronous reset also clears the coefficient file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      for (int i = 0; i < int'(TAPS); i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      base_q      <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      coef_q      <= coef_d;
      wr_ptr_q    <= wr_ptr_d;
      base_q      <= base_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
